// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
// Sums COUNT consecutive unsigned products into one ACC_W-bit block result,
// saturating to all-ones on overflow. The result is offered on a valid/ready
// output, and input is stalled while a result is waiting to be taken.
module mul_product_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             overflow,
  input  logic             out_ready,
  output logic             busy
);

  // cnt is kept at least one bit wide so COUNT==1 still has a legal register.
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_overflow;

  state_t             w_state_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;
  logic               w_out_valid_nxt;
  logic [ACC_W-1:0]   w_out_data_nxt;
  logic               w_overflow_nxt;

  logic               w_accept;
  logic [ACC_W:0]     w_sat;

  // Saturating add: returns {ovf_next, acc_next}. Once a block has saturated it
  // stays pinned at all-ones until the block completes.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic             ovf,
                                             input logic [IN_W-1:0]  d);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + (ACC_W+1)'(d);
    if (sum[ACC_W] || ovf) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign w_accept = in_valid && (r_state == ST_ACCUM);
  assign w_sat    = sat_add(r_acc, r_ovf, in_data);

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign in_ready  = reset && (r_state == ST_ACCUM);
  assign busy      = reset && ((r_cnt != '0) || (r_state == ST_HOLD));
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

  // Next-state and datapath update: clear beats everything, then the FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_overflow_nxt  = r_overflow;

    if (clear) begin
      // out_data is left as-is; it is simply no longer marked valid.
      w_state_nxt     = ST_ACCUM;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_ovf_nxt       = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_overflow_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (r_cnt == LAST_CNT) begin
              w_out_data_nxt  = w_sat[ACC_W-1:0];
              w_overflow_nxt  = w_sat[ACC_W];
              w_out_valid_nxt = 1'b1;
              w_acc_nxt       = '0;
              w_cnt_nxt       = '0;
              w_ovf_nxt       = 1'b0;
              w_state_nxt     = ST_HOLD;
            end else begin
              w_acc_nxt = w_sat[ACC_W-1:0];
              w_ovf_nxt = w_sat[ACC_W];
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_ACCUM;
          end
        end
        default: w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Bench for mul_product_accumulator: a 12-bit and a 9-bit instance share all
// inputs; each has its own scoreboard queue of expected block results.
module tb_mul_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready, out_valid, overflow, busy;
  logic [11:0] out_data;
  logic        in_ready9, out_valid9, overflow9, busy9;
  logic [8:0]  out_data9;

  int checks   = 0;
  int failures = 0;

  // Expected results encoded as (overflow << 16) | data.
  int q12[$];
  int q9[$];

  always #5 clk = ~clk;

  mul_product_accumulator #(.IN_W(8), .ACC_W(12), .COUNT(4)) dut (
    .clk(clk), .reset(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .overflow(overflow), .out_ready(out_ready), .busy(busy)
  );

  mul_product_accumulator #(.IN_W(8), .ACC_W(9), .COUNT(4)) dut9 (
    .clk(clk), .reset(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready9), .out_valid(out_valid9), .out_data(out_data9),
    .overflow(overflow9), .out_ready(out_ready), .busy(busy9)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference block sum: saturating unsigned add at the given width.
  function automatic int ref_block(input int v0, input int v1, input int v2, input int v3,
                                   input int w);
    int vals[4];
    int maxv;
    int acc;
    int ovf;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    maxv = (1 << w) - 1;
    acc  = 0;
    ovf  = 0;
    for (int i = 0; i < 4; i++) begin
      if (ovf != 0 || acc + vals[i] > maxv) begin
        acc = maxv;
        ovf = 1;
      end else begin
        acc = acc + vals[i];
      end
    end
    return (ovf << 16) | acc;
  endfunction

  task automatic push_exp(input int v0, input int v1, input int v2, input int v3);
    q12.push_back(ref_block(v0, v1, v2, v3, 12));
    q9.push_back(ref_block(v0, v1, v2, v3, 9));
  endtask

  // Output monitor: every handshake pops one expected result per instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (q12.size() == 0) chk("unexpected_out12", 1, 0);
        else begin
          int e;
          e = q12.pop_front();
          chk("sb12_data", 32'(out_data), 32'(e & 16'hFFFF));
          chk("sb12_ovf", 32'(overflow), 32'(e >> 16));
        end
      end
      if (out_valid9 === 1'b1) begin
        if (q9.size() == 0) chk("unexpected_out9", 1, 0);
        else begin
          int e;
          e = q9.pop_front();
          chk("sb9_data", 32'(out_data9), 32'(e & 16'hFFFF));
          chk("sb9_ovf", 32'(overflow9), 32'(e >> 16));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d);
    in_valid = 1'b1;
    in_data  = 8'(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Raise out_ready until a result appears (bounded), then complete the handshake.
  task automatic wait_out(input string tag);
    bit seen;
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_block(input string tag, input int v0, input int v1, input int v2,
                           input int v3);
    feed(v0); feed(v1); feed(v2); feed(v3);
    push_exp(v0, v1, v2, v3);
    wait_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_in_ready9", 32'(in_ready9), 0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 1);
    tick();

    // Basic block 15+30+45+225 = 315
    feed(15); feed(30); feed(45); feed(225);
    push_exp(15, 30, 45, 225);
    @(negedge clk);
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_out_data", 32'(out_data), 315);
    chk("basic_overflow", 32'(overflow), 0);
    chk("basic_in_ready", 32'(in_ready), 0);
    chk("basic_busy", 32'(busy), 1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("basic_done_valid", 32'(out_valid), 0);
    chk("basic_done_in_ready", 32'(in_ready), 1);
    chk("basic_done_busy", 32'(busy), 0);
    tick();

    // Saturation (9-bit instance saturates, 12-bit does not), then a clean block
    run_block("sat", 225, 225, 225, 225);
    run_block("after_sat", 1, 1, 1, 1);

    // Backpressure: result 100 held while 9s are offered
    feed(25); feed(25); feed(25); feed(25);
    push_exp(25, 25, 25, 25);
    in_valid = 1'b1;
    in_data  = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 100);
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    wait_out("bp");
    @(negedge clk);
    chk("bp_busy_after", 32'(busy), 0);
    tick();
    run_block("bp_next", 1, 2, 3, 4);

    // Gaps and clear with a simultaneous product
    feed(10);
    repeat (3) tick();
    feed(20);
    @(negedge clk);
    chk("gap_busy", 32'(busy), 1);
    tick();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", 32'(busy), 0);
    chk("clear_out_valid", 32'(out_valid), 0);
    tick();
    run_block("after_clear", 1, 2, 3, 4);

    // Asynchronous reset between edges in mid-block
    feed(7); feed(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_in_ready", 32'(in_ready), 0);
    chk("areset_out_valid", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_rel_in_ready", 32'(in_ready), 1);
    tick();
    run_block("after_areset", 5, 5, 5, 5);

    chk("sb12_empty", 32'(q12.size()), 0);
    chk("sb9_empty", 32'(q9.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
